// File: rtl/serial_dot_product.sv
// serial_dot_product
//   Bit-serial binary dot-product engine. Captures two WIDTH-bit operands on
//   start. Each RUN cycle it combines LANES bit-pairs with AND (mode=0) or
//   XNOR (mode=1) and adds their popcount to a running sum. It then reports the
//   sum with a one-cycle done pulse.
//
//   Optional feature macro: SDP_ACCUM_EN. When defined, this adds a saturating
//   running accumulator of results (acc) and a synchronous clear (acc_clear).
//
// Ports
//   clock      in   1      single clock, posedge
//   reset      in   1      synchronous, active-high
//   start      in   1      request, sampled only in IDLE
//   mode       in   1      0 = AND, 1 = XNOR (latched on accept)
//   a, b       in   WIDTH  operands (latched on accept)
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse, result valid
//   result     out  OUT_W  last completed result, held until next done
//   acc_clear  in   1      [SDP_ACCUM_EN] synchronous accumulator clear
//   acc        out  ACC_W  [SDP_ACCUM_EN] saturating sum of results
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | consuming LANES bit-pairs per cycle, STEPS cycles
// DONE   | result valid, done pulse, back to IDLE
module serial_dot_product #(
  parameter int WIDTH = 16,
  parameter int LANES = 1,
  parameter int ACC_W = 16,
  localparam int STEPS = WIDTH / LANES,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result
`ifdef SDP_ACCUM_EN
  ,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] acc
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int PC_W  = $clog2(LANES + 1);
  // A single-step configuration still needs a 1-bit counter.
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] sum_next;
  logic [LANES-1:0] pair;
  logic [PC_W-1:0]  pc;
  logic             last_step;

  assign pair = mode_q ? ~(a_sh[LANES-1:0] ^ b_sh[LANES-1:0])
                       :  (a_sh[LANES-1:0] & b_sh[LANES-1:0]);

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PC_W'(pair[i]);
    end
  end

  // sum never exceeds WIDTH, so OUT_W bits cannot overflow.
  assign sum_next  = sum + OUT_W'(pc);
  assign last_step = (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            sum    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          sum  <= sum_next;
          a_sh <= a_sh >> LANES;
          b_sh <= b_sh >> LANES;
          cnt  <= cnt + CNT_W'(1);
          if (last_step) begin
            // Load result on the final step so it is valid alongside done.
            result <= sum_next;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

`ifdef SDP_ACCUM_EN
  // One extra bit over the wider operand keeps the raw sum exact before
  // saturation, even when OUT_W exceeds ACC_W.
  localparam int SUM_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [SUM_W-1:0] acc_base;
  logic [SUM_W-1:0] acc_sum;

  // Clear coinciding with done means clear first, then add.
  assign acc_base = acc_clear ? '0 : SUM_W'(acc);
  assign acc_sum  = acc_base + SUM_W'(result);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (state == S_DONE) begin
      acc <= (acc_sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : acc_sum[ACC_W-1:0];
    end else if (acc_clear) begin
      acc <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_serial_dot_product.sv
// tb_serial_dot_product
//   Scoreboard bench for serial_dot_product. Stimulus pushes hand-computed
//   results into per-instance queues. Monitors pop them on every done pulse.
//   Instances: u0 (LANES=1), u1 (LANES=4), and u2 (LANES=16, ACC_W=5).
//   u2 exists only with SDP_ACCUM_EN.
module tb_serial_dot_product;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic        rst0, start0, mode0, busy0, done0;
  logic [15:0] a0, b0;
  logic [4:0]  res0;
  logic        rst1, start1, mode1, busy1, done1;
  logic [15:0] a1, b1;
  logic [4:0]  res1;
  int q0[$];
  int q1[$];
`ifdef SDP_ACCUM_EN
  logic        acc_clear0, acc_clear1, acc_clear2;
  logic [15:0] acc0, acc1;
  logic        start2, mode2, busy2, done2;
  logic [15:0] a2, b2;
  logic [4:0]  res2, acc2;
  int q2[$];
`endif

  serial_dot_product #(.WIDTH(16), .LANES(1), .ACC_W(16)) u0 (
    .clock(clock), .reset(rst0), .start(start0), .mode(mode0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .result(res0)
`ifdef SDP_ACCUM_EN
    , .acc_clear(acc_clear0), .acc(acc0)
`endif
  );

  serial_dot_product #(.WIDTH(16), .LANES(4), .ACC_W(16)) u1 (
    .clock(clock), .reset(rst1), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(res1)
`ifdef SDP_ACCUM_EN
    , .acc_clear(acc_clear1), .acc(acc1)
`endif
  );

`ifdef SDP_ACCUM_EN
  serial_dot_product #(.WIDTH(16), .LANES(16), .ACC_W(5)) u2 (
    .clock(clock), .reset(rst1), .start(start2), .mode(mode2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(res2), .acc_clear(acc_clear2), .acc(acc2)
  );
`endif

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) check("u0_unexpected_done", 1, 0);
      else check("u0_result", int'(res0), q0.pop_front());
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("u1_unexpected_done", 1, 0);
      else check("u1_result", int'(res1), q1.pop_front());
    end
`ifdef SDP_ACCUM_EN
    if (done2 === 1'b1) begin
      if (q2.size() == 0) check("u2_unexpected_done", 1, 0);
      else check("u2_result", int'(res2), q2.pop_front());
    end
`endif
  end

  function automatic logic busy_of(input int u);
    case (u)
      0:       return busy0;
`ifdef SDP_ACCUM_EN
      2:       return busy2;
`endif
      default: return busy1;
    endcase
  endfunction

  task automatic wait_idle(input int u);
    int n = 0;
    while (busy_of(u) !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check($sformatf("u%0d_idle_timeout", u), 0, 1);
  endtask

  // Returns 1ns after the accepting edge. Inputs are scrambled there so
  // latching is exercised.
  task automatic issue(input int u, input logic m, input logic [15:0] va,
                       input logic [15:0] vb, input int exp);
    wait_idle(u);
    case (u)
      0: begin start0 = 1; mode0 = m; a0 = va; b0 = vb; q0.push_back(exp); end
`ifdef SDP_ACCUM_EN
      2: begin start2 = 1; mode2 = m; a2 = va; b2 = vb; q2.push_back(exp); end
`endif
      default: begin start1 = 1; mode1 = m; a1 = va; b1 = vb; q1.push_back(exp); end
    endcase
    @(posedge clock);
    #1;
    case (u)
      0: begin start0 = 0; mode0 = ~m; a0 = 16'($urandom); b0 = 16'($urandom); end
`ifdef SDP_ACCUM_EN
      2: begin start2 = 0; mode2 = ~m; a2 = 16'($urandom); b2 = 16'($urandom); end
`endif
      default: begin start1 = 0; mode1 = ~m; a1 = 16'($urandom); b1 = 16'($urandom); end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    rst0 = 1; rst1 = 1;
    start0 = 0; mode0 = 0; a0 = '0; b0 = '0;
    start1 = 0; mode1 = 0; a1 = '0; b1 = '0;
`ifdef SDP_ACCUM_EN
    acc_clear0 = 0; acc_clear1 = 0; acc_clear2 = 0;
    start2 = 0; mode2 = 0; a2 = '0; b2 = '0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy0", int'(busy0), 0);
    check("reset_done0", int'(done0), 0);
    check("reset_result0", int'(res0), 0);
    check("reset_busy1", int'(busy1), 0);
`ifdef SDP_ACCUM_EN
    check("reset_acc0", int'(acc0), 0);
`endif
    rst0 = 0; rst1 = 0;

    // AND, LANES=1: busy from the first cycle after accept, done only at the 17th.
    issue(0, 1'b0, 16'hFFFF, 16'h00FF, 8);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      check($sformatf("t1_busy_%0d", k), int'(busy0), (k <= 17) ? 1 : 0);
      check($sformatf("t1_done_%0d", k), int'(done0), (k == 17) ? 1 : 0);
    end

    // XNOR, plus latching with inputs scrambled during RUN.
    issue(0, 1'b1, 16'hAAAA, 16'h5555, 0);
    issue(0, 1'b1, 16'h1234, 16'h1234, 16);
    issue(0, 1'b0, 16'hF0F0, 16'hFF00, 4);
    issue(0, 1'b1, 16'hF0F0, 16'hFF00, 8);
    issue(0, 1'b0, 16'h0001, 16'h0001, 1);
    issue(0, 1'b0, 16'h8000, 16'h8000, 1);
    issue(0, 1'b1, 16'h0000, 16'h0000, 16);

    // LANES=4: done at the 5th cycle after accept.
    issue(1, 1'b0, 16'hFFFF, 16'hFFFF, 16);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check($sformatf("t3_busy_%0d", k), int'(busy1), (k <= 5) ? 1 : 0);
      check($sformatf("t3_done_%0d", k), int'(done1), (k == 5) ? 1 : 0);
    end
    issue(1, 1'b0, 16'h8001, 16'hFFFF, 2);
    issue(1, 1'b1, 16'h8001, 16'h7FFE, 0);
    issue(1, 1'b1, 16'h00F0, 16'h0FF0, 12);
    wait_idle(1);

    // start held high: one op per IDLE visit, period 18. Reset then aborts the third op.
    wait_idle(0);
    @(negedge clock);
    start0 = 1; mode0 = 0; a0 = 16'hFFFF; b0 = 16'h00FF;
    q0.push_back(8);
    q0.push_back(8);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      check($sformatf("t4_done_%0d", k), int'(done0), (k == 17 || k == 35) ? 1 : 0);
      if (k == 40) start0 = 0;
    end
    @(negedge clock);
    check("t4_busy_run5", int'(busy0), 1);
    rst0 = 1;
    @(negedge clock);
    check("t4_rst_busy", int'(busy0), 0);
    check("t4_rst_result", int'(res0), 0);
    check("t4_rst_done", int'(done0), 0);
    rst0 = 0;
    nd = 0;
    repeat (25) begin
      @(negedge clock);
      if (done0 === 1'b1) nd++;
    end
    check("t4_no_done_after_abort", nd, 0);

`ifdef SDP_ACCUM_EN
    check("acc_after_reset", int'(acc0), 0);
    issue(0, 1'b0, 16'hFFFF, 16'h00FF, 8);
    issue(0, 1'b1, 16'h1234, 16'h1234, 16);
    issue(0, 1'b0, 16'h0007, 16'h0007, 3);
    wait_idle(0);
    check("acc_27", int'(acc0), 27);
    issue(0, 1'b0, 16'h001F, 16'h001F, 5);
    nd = 0;
    do begin
      @(negedge clock);
      nd++;
    end while (done0 !== 1'b1 && nd < 100);
    if (nd >= 100) check("acc_done_timeout", 0, 1);
    acc_clear0 = 1;
    @(posedge clock);
    #1 acc_clear0 = 0;
    @(negedge clock);
    check("acc_clear_with_done", int'(acc0), 5);
    acc_clear0 = 1;
    @(posedge clock);
    #1 acc_clear0 = 0;
    @(negedge clock);
    check("acc_clear_alone", int'(acc0), 0);

    issue(2, 1'b0, 16'hFFFF, 16'hFFFF, 16);
    wait_idle(2);
    check("acc5_first", int'(acc2), 16);
    issue(2, 1'b1, 16'h5A5A, 16'h5A5A, 16);
    wait_idle(2);
    check("acc5_saturated", int'(acc2), 31);
`endif

    wait_idle(0);
    wait_idle(1);
    repeat (2) @(negedge clock);
    check("u0_queue_drained", q0.size(), 0);
    check("u1_queue_drained", q1.size(), 0);
`ifdef SDP_ACCUM_EN
    check("u2_queue_drained", q2.size(), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
